// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard between decode and execute: tracks pending register
// writes, stalls issue on RAW/WAW/in-flight limit. Optional macro SCOREBOARD_WB_BYPASS_EN.
module issue_scoreboard #(
  parameter int NREGS        = 32,
  parameter int AW           = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_dec_valid,
  output logic             o_dec_ready,
  input  logic             i_dec_rd_valid,
  input  logic [AW-1:0]    i_dec_rd_waddr,
  input  logic             i_dec_rs1_valid,
  input  logic [AW-1:0]    i_dec_rs1_raddr,
  input  logic             i_dec_rs2_valid,
  input  logic [AW-1:0]    i_dec_rs2_raddr,
  input  logic             i_wb_valid,
  input  logic [AW-1:0]    i_wb_rd_waddr,
  output logic             o_stall_rs1,
  output logic             o_stall_rs2,
  output logic             o_stall_waw,
  output logic             o_stall_full,
  output logic [NREGS-1:0] o_busy,
  output logic [CW-1:0]    o_inflight,
  output logic             o_err
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

  logic [NREGS-1:1] busy_q, busy_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic             err_q, err_d;

  logic [NREGS-1:0] busy_vec;
  logic [NREGS-1:0] eff_busy;
  logic [NREGS-1:1] wb_mask;
  logic [NREGS-1:1] set_mask;
  logic             tracked;
  logic             wb_hit;
  logic             full;
  logic             any_stall;
  logic             issue;
  logic             inc;

  assign busy_vec = {busy_q, 1'b0};
  assign tracked  = i_dec_rd_valid & (i_dec_rd_waddr != '0);
  assign wb_hit   = i_wb_valid & (i_wb_rd_waddr != '0) & busy_vec[i_wb_rd_waddr];

  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    for (int r = 1; r < NREGS; r++) begin
      wb_mask[r]  = wb_hit & (i_wb_rd_waddr == AW'(r));
      set_mask[r] = inc & (i_dec_rd_waddr == AW'(r));
    end
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  // A register being written back this cycle is already readable and free.
  assign eff_busy = {busy_q & ~wb_mask, 1'b0};
  assign full     = (inflight_q == MAX_CNT) & ~wb_hit;
`else
  assign eff_busy = busy_vec;
  assign full     = (inflight_q == MAX_CNT);
`endif

  assign o_stall_rs1  = i_dec_rs1_valid & eff_busy[i_dec_rs1_raddr];
  assign o_stall_rs2  = i_dec_rs2_valid & eff_busy[i_dec_rs2_raddr];
  assign o_stall_waw  = tracked & eff_busy[i_dec_rd_waddr];
  assign o_stall_full = tracked & full;
  assign any_stall    = o_stall_rs1 | o_stall_rs2 | o_stall_waw | o_stall_full;

  // Ready never looks at i_dec_valid so decode can use it to decide validity.
  assign o_dec_ready = ~rst & ~any_stall;
  assign issue       = i_dec_valid & o_dec_ready;
  assign inc         = issue & tracked;

  always_comb begin
    // Set after clear so a same-cycle set on the written-back register wins.
    busy_d     = (busy_q & ~wb_mask) | set_mask;
    inflight_d = inflight_q;
    unique case ({inc, wb_hit})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    err_d = err_q | (i_wb_valid & ~wb_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign o_busy     = busy_vec;
  assign o_inflight = inflight_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them.
module tb_issue_scoreboard;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int MAXI  = 4;
  localparam int CW    = $clog2(MAXI + 1);

  localparam int S_RDY = 0, S_RS1 = 1, S_RS2 = 2, S_WAW = 3, S_FULL = 4,
                 S_BUSY = 5, S_INF = 6, S_ERR = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             dec_valid, dec_ready;
  logic             rd_valid, rs1_valid, rs2_valid;
  logic [AW-1:0]    rd_addr, rs1_addr, rs2_addr;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic             st_rs1, st_rs2, st_waw, st_full;
  logic [NREGS-1:0] busy;
  logic [CW-1:0]    inflight;
  logic             err;

  issue_scoreboard #(.NREGS(NREGS), .AW(AW), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst),
    .i_dec_valid(dec_valid), .o_dec_ready(dec_ready),
    .i_dec_rd_valid(rd_valid), .i_dec_rd_waddr(rd_addr),
    .i_dec_rs1_valid(rs1_valid), .i_dec_rs1_raddr(rs1_addr),
    .i_dec_rs2_valid(rs2_valid), .i_dec_rs2_raddr(rs2_addr),
    .i_wb_valid(wb_valid), .i_wb_rd_waddr(wb_addr),
    .o_stall_rs1(st_rs1), .o_stall_rs2(st_rs2), .o_stall_waw(st_waw),
    .o_stall_full(st_full), .o_busy(busy), .o_inflight(inflight), .o_err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          q_cyc[$];
  int          q_sel[$];
  int          q_id[$];
  logic [63:0] q_val[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          id_ctr = 0;

  function automatic string sel_name(int s);
    case (s)
      S_RDY:   return "ready";
      S_RS1:   return "stall_rs1";
      S_RS2:   return "stall_rs2";
      S_WAW:   return "stall_waw";
      S_FULL:  return "stall_full";
      S_BUSY:  return "busy";
      S_INF:   return "inflight";
      default: return "err";
    endcase
  endfunction

  function automatic logic [63:0] actual(int s);
    case (s)
      S_RDY:   return 64'(dec_ready);
      S_RS1:   return 64'(st_rs1);
      S_RS2:   return 64'(st_rs2);
      S_WAW:   return 64'(st_waw);
      S_FULL:  return 64'(st_full);
      S_BUSY:  return 64'(busy);
      S_INF:   return 64'(inflight);
      default: return 64'(err);
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      int          c, s, id;
      logic [63:0] v, a;
      c = q_cyc.pop_front(); s = q_sel.pop_front();
      id = q_id.pop_front(); v = q_val.pop_front();
      a = actual(s);
      n_total++;
      if (c < cyc)
        $display("FAIL #%0d %s: check missed (due cycle %0d, now %0d)", id, sel_name(s), c, cyc);
      else if (a !== v)
        $display("FAIL #%0d %s @cycle %0d: got 0x%0h expected 0x%0h", id, sel_name(s), cyc, a, v);
      else
        n_pass++;
    end
  end

  task automatic expect_now(int s, logic [63:0] v);
    q_cyc.push_back(cyc); q_sel.push_back(s); q_id.push_back(id_ctr); q_val.push_back(v);
    id_ctr++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(logic v, logic rdv, int rd, logic r1v, int r1, logic r2v, int r2);
    dec_valid = v;
    rd_valid  = rdv; rd_addr  = AW'(rd);
    rs1_valid = r1v; rs1_addr = AW'(r1);
    rs2_valid = r2v; rs2_addr = AW'(r2);
  endtask

  task automatic wb(logic v, int a);
    wb_valid = v; wb_addr = AW'(a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    dec(0, 0, 0, 0, 0, 0, 0);
    wb(0, 0);
    step();
    // Reset: ready held low even with a hazard-free instruction presented.
    dec(1, 1, 10, 0, 0, 0, 0);
    expect_now(S_RDY, 0);
    step();
    rst = 1'b0;
    dec(0, 0, 0, 0, 0, 0, 0);
    expect_now(S_BUSY, 0); expect_now(S_INF, 0); expect_now(S_ERR, 0);
    expect_now(S_RDY, 1);

    // Issue rd=x5.
    dec(1, 1, 5, 0, 0, 0, 0);
    expect_now(S_RDY, 1);
    step();
    dec(0, 0, 0, 0, 0, 0, 0);
    expect_now(S_BUSY, 64'h20); expect_now(S_INF, 1); expect_now(S_ERR, 0);

    // RAW on x5, then writeback x5 at cycle N.
    dec(1, 0, 0, 1, 5, 0, 0);
    expect_now(S_RDY, 0); expect_now(S_RS1, 1);
    step();
    wb(1, 5);
`ifdef SCOREBOARD_WB_BYPASS_EN
    expect_now(S_RDY, 1); expect_now(S_RS1, 0);
`else
    expect_now(S_RDY, 0); expect_now(S_RS1, 1);
`endif
    step();
    wb(0, 0);
    expect_now(S_RDY, 1); expect_now(S_RS1, 0);
    expect_now(S_BUSY, 0); expect_now(S_INF, 0); expect_now(S_ERR, 0);
    step();

    // rd=x0 with rs1=x0, rs2=x0: never stalls, untracked.
    dec(1, 1, 0, 1, 0, 1, 0);
    expect_now(S_RDY, 1); expect_now(S_RS1, 0); expect_now(S_RS2, 0);
    expect_now(S_WAW, 0); expect_now(S_FULL, 0);
    step();
    dec(0, 0, 0, 0, 0, 0, 0);
    expect_now(S_BUSY, 0); expect_now(S_INF, 0);

    // Fill to the in-flight limit with x1..x4.
    for (int r = 1; r <= 4; r++) begin
      dec(1, 1, r, 0, 0, 0, 0);
      expect_now(S_RDY, 1);
      step();
    end
    dec(0, 0, 0, 0, 0, 0, 0);
    expect_now(S_BUSY, 64'h1E); expect_now(S_INF, 4);

    dec(1, 1, 6, 0, 0, 0, 0);
    expect_now(S_FULL, 1); expect_now(S_RDY, 0);
    step();
    expect_now(S_INF, 4); expect_now(S_BUSY, 64'h1E);

    // Store reading x7/x8 is untracked and ignores the full limit.
    dec(1, 0, 0, 1, 7, 1, 8);
    expect_now(S_RDY, 1); expect_now(S_FULL, 0);
    step();
    expect_now(S_INF, 4); expect_now(S_BUSY, 64'h1E);

    // rd=x6 waiting on full; writeback x2 frees a slot.
    dec(1, 1, 6, 0, 0, 0, 0);
    wb(1, 2);
`ifdef SCOREBOARD_WB_BYPASS_EN
    expect_now(S_RDY, 1); expect_now(S_FULL, 0);
`else
    expect_now(S_RDY, 0); expect_now(S_FULL, 1);
`endif
    step();
    wb(0, 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    dec(0, 0, 0, 0, 0, 0, 0);
    expect_now(S_INF, 4); expect_now(S_BUSY, 64'h5A);
`else
    expect_now(S_INF, 3); expect_now(S_BUSY, 64'h1A); expect_now(S_RDY, 1);
`endif
    step();
    dec(0, 0, 0, 0, 0, 0, 0);
    expect_now(S_INF, 4); expect_now(S_BUSY, 64'h5A); expect_now(S_ERR, 0);

    // Writeback to non-busy x9: sticky error, state unchanged.
    wb(1, 9);
    step();
    wb(1, 1);
    expect_now(S_ERR, 1); expect_now(S_BUSY, 64'h5A); expect_now(S_INF, 4);
    step();
    wb(1, 6);
    expect_now(S_ERR, 1); expect_now(S_BUSY, 64'h58); expect_now(S_INF, 3);
    step();
    wb(0, 0);
    expect_now(S_ERR, 1); expect_now(S_BUSY, 64'h18); expect_now(S_INF, 2);

    // WAW on x3 and RAW on rs2=x4.
    dec(1, 1, 3, 0, 0, 1, 4);
    expect_now(S_WAW, 1); expect_now(S_RS2, 1); expect_now(S_RDY, 0);
    step();
    dec(0, 0, 0, 0, 0, 0, 0);
    expect_now(S_INF, 2); expect_now(S_BUSY, 64'h18);

    // Reset with a concurrent writeback x3.
    rst = 1'b1;
    wb(1, 3);
    dec(1, 1, 10, 0, 0, 0, 0);
    expect_now(S_RDY, 0); expect_now(S_INF, 2);
    step();
    rst = 1'b0;
    wb(0, 0);
    dec(0, 0, 0, 0, 0, 0, 0);
    expect_now(S_BUSY, 0); expect_now(S_INF, 0); expect_now(S_ERR, 0);
    expect_now(S_RDY, 1);
    step();
    step();

    if (q_cyc.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q_cyc.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
